// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: blanked digit scanning with
// per-frame shadow capture, per-digit lit mask and frame-based blinking.
module sseg_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned DWELL_CYCLES = 700000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned BLINK_FRAMES = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [8*N_DIGITS-1:0]   seg_data,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic [N_DIGITS-1:0]     blink_en,
  output logic [7:0]              an,
  output logic [7:0]              sseg,
  output logic                    frame_done
);

  localparam int unsigned IW         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CMAX       = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW         = $clog2(CMAX + 1);
  localparam int unsigned FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DWELL_LAST = DWELL_CYCLES - 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [CW-1:0]           r_cnt;
  logic [FW-1:0]           r_fcnt;
  logic                    r_blink_phase;
  logic [8*N_DIGITS-1:0]   r_seg_sh;
  logic [N_DIGITS-1:0]     r_den_sh;
  logic [N_DIGITS-1:0]     r_ben_sh;
  logic [7:0]              r_an;
  logic [7:0]              r_sseg;
  logic                    r_frame_done;

  logic                    w_last_digit;
  logic                    w_fcnt_wrap;
  logic                    w_phase_nxt;
  logic [IW-1:0]           w_idx_inc;

  assign w_last_digit = (r_idx == IW'(N_DIGITS - 1));
  assign w_fcnt_wrap  = (r_fcnt == FW'(BLINK_FRAMES - 1));
  assign w_phase_nxt  = w_fcnt_wrap ? ~r_blink_phase : r_blink_phase;
  assign w_idx_inc    = IW'(r_idx + 1'b1);

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign frame_done = r_frame_done;

  // Anode pattern for a driven digit: dark when masked off or in the blink-off phase.
  function automatic logic [7:0] f_an(input logic [IW-1:0] idx, input logic [N_DIGITS-1:0] den,
                                      input logic [N_DIGITS-1:0] ben, input logic phase);
    logic [7:0] v;
    v = 8'hFF;
    if (den[idx] && !(ben[idx] && phase)) v[idx] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] f_seg(input logic [IW-1:0] idx, input logic [8*N_DIGITS-1:0] seg);
    return seg[8*int'(idx) +: 8];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
      r_seg_sh      <= '1;
      r_den_sh      <= '0;
      r_ben_sh      <= '0;
      r_an          <= 8'hFF;
      r_sseg        <= 8'hFF;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_an   <= 8'hFF;
          r_sseg <= 8'hFF;
          if (enable) begin
            r_seg_sh <= seg_data;
            r_den_sh <= digit_en;
            r_ben_sh <= blink_en;
            r_idx    <= '0;
            r_cnt    <= '0;
            if (BLANK_CYCLES == 0) begin
              r_state <= S_DRIVE;
              r_an    <= f_an('0, digit_en, blink_en, r_blink_phase);
              r_sseg  <= f_seg('0, seg_data);
            end else begin
              r_state <= S_BLANK;
            end
          end
        end

        S_BLANK: begin
          if (r_cnt == CW'(BLANK_LAST)) begin
            r_state <= S_DRIVE;
            r_cnt   <= '0;
            r_an    <= f_an(r_idx, r_den_sh, r_ben_sh, r_blink_phase);
            r_sseg  <= f_seg(r_idx, r_seg_sh);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DRIVE: begin
          if (r_cnt == CW'(DWELL_LAST)) begin
            // enable is only looked at here, so a digit always completes its dwell
            r_cnt        <= '0;
            r_an         <= 8'hFF;
            r_sseg       <= 8'hFF;
            r_frame_done <= w_last_digit;
            r_state      <= (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
            if (!enable) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
            end else if (w_last_digit) begin
              r_idx         <= '0;
              r_seg_sh      <= seg_data;
              r_den_sh      <= digit_en;
              r_ben_sh      <= blink_en;
              r_fcnt        <= w_fcnt_wrap ? '0 : FW'(r_fcnt + 1'b1);
              r_blink_phase <= w_phase_nxt;
              if (BLANK_CYCLES == 0) begin
                r_an   <= f_an('0, digit_en, blink_en, w_phase_nxt);
                r_sseg <= f_seg('0, seg_data);
              end
            end else begin
              r_idx <= w_idx_inc;
              if (BLANK_CYCLES == 0) begin
                r_an   <= f_an(w_idx_inc, r_den_sh, r_ben_sh, r_blink_phase);
                r_sseg <= f_seg(w_idx_inc, r_seg_sh);
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
